// File: rtl/exa_crosb_pkg.sv
// Shared types and defaults for the crossbar output arbiter slice.
package exa_crosb_pkg;

  localparam int unsigned InputNumDefault = 16;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/exa_crosb_out_arbiter_if.sv
// Request/grant bundle between the input buffers, the output arbiter and the crossbar mux.
interface exa_crosb_out_arbiter_if
  import exa_crosb_pkg::*;
#(
  parameter int unsigned input_num = InputNumDefault,
  parameter int unsigned sel_width = $clog2(input_num)
);

  logic [input_num-1:0] REQ_i;
  logic [input_num-1:0] PRIO_i;
  logic [input_num-1:0] LAST_i;
  logic                 READY_i;
  logic [sel_width-1:0] SEL_o;
  logic [input_num-1:0] GRANT_o;
  logic [input_num-1:0] POP_o;
  logic                 BUSY_o;

  modport master (
    input  REQ_i, PRIO_i, LAST_i, READY_i,
    output SEL_o, GRANT_o, POP_o, BUSY_o
  );

  modport slave (
    output REQ_i, PRIO_i, LAST_i, READY_i,
    input  SEL_o, GRANT_o, POP_o, BUSY_o
  );

endinterface

// File: rtl/exa_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping at input_num.
module exa_rr_pick #(
  parameter int unsigned input_num = 16,
  parameter int unsigned sel_width = $clog2(input_num)
) (
  input  logic [input_num-1:0] req,
  input  logic [sel_width-1:0] ptr,
  output logic                 found,
  output logic [sel_width-1:0] idx
);

  logic [sel_width:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < input_num; i++) begin
      pos = {1'b0, ptr} + (sel_width + 1)'(i);
      // Wrap manually so non-power-of-two port counts never produce an out-of-range index.
      if (pos >= (sel_width + 1)'(input_num)) begin
        pos = pos - (sel_width + 1)'(input_num);
      end
      if (!found && req[pos[sel_width-1:0]]) begin
        found = 1'b1;
        idx   = pos[sel_width-1:0];
      end
    end
  end

endmodule

// File: rtl/exa_crosb_out_arbiter.sv
// Per-output crossbar arbiter: round-robin grant held for a whole packet.
// Define EXA_CROSB_ARB_PRIO_EN to enable the separate high-priority class and its pointer.
module exa_crosb_out_arbiter
  import exa_crosb_pkg::*;
#(
  parameter int unsigned input_num = InputNumDefault,
  parameter int unsigned sel_width = $clog2(input_num)
) (
  input logic                    clk,
  input logic                    resetn,
  exa_crosb_out_arbiter_if.master arb
);

  arb_state_t           state_q, state_d;
  logic [sel_width-1:0] sel_q, sel_d;
  logic [input_num-1:0] grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [sel_width-1:0] rr_lo_q, rr_lo_d;

  logic                 lo_found;
  logic [sel_width-1:0] lo_idx;
  logic                 win_hi;
  logic [sel_width-1:0] win_idx;
  logic                 xfer_last;
  logic [sel_width-1:0] ptr_next;

  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pick_lo (
    .req   (arb.REQ_i),
    .ptr   (rr_lo_q),
    .found (lo_found),
    .idx   (lo_idx)
  );

`ifdef EXA_CROSB_ARB_PRIO_EN
  logic [sel_width-1:0] rr_hi_q, rr_hi_d;
  logic                 cls_q, cls_d;
  logic                 hi_found;
  logic [sel_width-1:0] hi_idx;

  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pick_hi (
    .req   (arb.REQ_i & arb.PRIO_i),
    .ptr   (rr_hi_q),
    .found (hi_found),
    .idx   (hi_idx)
  );

  assign win_hi = hi_found;
`else
  logic unused_prio;
  assign unused_prio = ^arb.PRIO_i;
  assign win_hi      = 1'b0;
`endif

  assign win_idx   = win_hi ? hi_idx_or_lo() : lo_idx;
  assign xfer_last = (state_q == ARB_LOCKED) && arb.REQ_i[sel_q] && arb.READY_i &&
                     arb.LAST_i[sel_q];
  assign ptr_next  = (sel_q == sel_width'(input_num - 1)) ? '0 : sel_q + sel_width'(1);

  function automatic logic [sel_width-1:0] hi_idx_or_lo();
`ifdef EXA_CROSB_ARB_PRIO_EN
    return hi_idx;
`else
    return lo_idx;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rr_lo_d = rr_lo_q;
`ifdef EXA_CROSB_ARB_PRIO_EN
    rr_hi_d = rr_hi_q;
    cls_d   = cls_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (|arb.REQ_i) begin
          state_d = ARB_LOCKED;
          sel_d   = win_idx;
          grant_d = input_num'(1) << win_idx;
          busy_d  = 1'b1;
`ifdef EXA_CROSB_ARB_PRIO_EN
          cls_d   = win_hi;
`endif
        end
      end
      ARB_LOCKED: begin
        // Bubbles and backpressure simply hold the lock; only the last transfer releases it.
        if (xfer_last) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
`ifdef EXA_CROSB_ARB_PRIO_EN
          if (cls_q) rr_hi_d = ptr_next;
          else       rr_lo_d = ptr_next;
`else
          rr_lo_d = ptr_next;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_lo_q <= '0;
`ifdef EXA_CROSB_ARB_PRIO_EN
      rr_hi_q <= '0;
      cls_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rr_lo_q <= rr_lo_d;
`ifdef EXA_CROSB_ARB_PRIO_EN
      rr_hi_q <= rr_hi_d;
      cls_q   <= cls_d;
`endif
    end
  end

  assign arb.SEL_o   = sel_q;
  assign arb.GRANT_o = grant_q;
  assign arb.BUSY_o  = busy_q;
  assign arb.POP_o   = grant_q & arb.REQ_i & {input_num{arb.READY_i}};

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// Bench for exa_crosb_out_arbiter: directed vector table, corner sequences, random vs. model.
module tb_exa_crosb_out_arbiter;

  localparam int N = 16;

  logic clk;
  logic resetn;

  exa_crosb_out_arbiter_if #(.input_num(N)) bus ();

  exa_crosb_out_arbiter #(.input_num(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .arb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Sampled DUT outputs of the current cycle.
  logic [3:0]   s_sel;
  logic [N-1:0] s_grant;
  logic         s_busy;
  logic [N-1:0] s_pop;

  // Behavioural reference: lock owner, per-class pointers, plain modulo arithmetic.
  bit m_valid = 0;
  bit m_busy;
  int m_owner;
  int m_sel;
  int m_cls;
  int m_ptr[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] cand, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (cand[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] pr,
                            input logic [N-1:0] la, input logic rd);
    logic [N-1:0] cand;
    int cls;
    if (!rn) begin
      m_valid  = 1;
      m_busy   = 0;
      m_sel    = 0;
      m_ptr[0] = 0;
      m_ptr[1] = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (rq != 0) begin
          cand = rq;
          cls  = 0;
`ifdef EXA_CROSB_ARB_PRIO_EN
          if ((rq & pr) != 0) begin
            cand = rq & pr;
            cls  = 1;
          end
`endif
          m_owner = pick(cand, m_ptr[cls]);
          m_cls   = cls;
          m_sel   = m_owner;
          m_busy  = 1;
        end
      end else if (rq[m_owner] && rd && la[m_owner]) begin
        m_busy       = 0;
        m_ptr[m_cls] = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic cyc(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] pr,
                     input logic [N-1:0] la, input logic rd);
    logic [N-1:0] e_grant;
    logic [N-1:0] e_pop;
    resetn      = rn;
    bus.REQ_i   = rq;
    bus.PRIO_i  = pr;
    bus.LAST_i  = la;
    bus.READY_i = rd;
    #2;
    s_sel   = bus.SEL_o;
    s_grant = bus.GRANT_o;
    s_busy  = bus.BUSY_o;
    s_pop   = bus.POP_o;
    if (m_valid) begin
      e_grant = m_busy ? N'(1) << m_owner : '0;
      e_pop   = (m_busy && rd && rq[m_owner]) ? N'(1) << m_owner : '0;
      chk("model_sel",   32'(s_sel),   32'(m_sel));
      chk("model_grant", 32'(s_grant), 32'(e_grant));
      chk("model_busy",  32'(s_busy),  32'(m_busy));
      chk("model_pop",   32'(s_pop),   32'(e_pop));
    end
    @(posedge clk);
    model_step(rn, rq, pr, la, rd);
    #1;
  endtask

  typedef struct {
    logic         rn;
    logic [N-1:0] req;
    logic [N-1:0] prio;
    logic [N-1:0] last;
    logic         rdy;
    logic         chk_en;
    logic [3:0]   sel;
    logic [N-1:0] grant;
    logic         busy;
    logic [N-1:0] pop;
  } vec_t;

  function automatic vec_t mk(logic rn, logic [N-1:0] req, logic [N-1:0] prio,
                              logic [N-1:0] last, logic rdy, logic chk_en, logic [3:0] sel,
                              logic [N-1:0] grant, logic busy, logic [N-1:0] pop);
    vec_t v;
    v.rn = rn; v.req = req; v.prio = prio; v.last = last; v.rdy = rdy;
    v.chk_en = chk_en; v.sel = sel; v.grant = grant; v.busy = busy; v.pop = pop;
    return v;
  endfunction

  vec_t tbl[13];
  int   grants[$];

  initial begin
    logic [3:0] w1;
`ifdef EXA_CROSB_ARB_PRIO_EN
    w1 = 4'd1;
`else
    w1 = 4'd0;
`endif
    // Reset, 3-flit packet on input 2, then priority arbitration between inputs 0 and 1.
    tbl[0]  = mk(0, 16'hFFFF, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 16'hFFFF, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 16'h0004, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 16'h0004, 0, 0, 1, 1, 2, 16'h0004, 1, 16'h0004);
    tbl[5]  = mk(1, 16'h0004, 0, 0, 1, 1, 2, 16'h0004, 1, 16'h0004);
    tbl[6]  = mk(1, 16'h0004, 0, 16'h0004, 1, 1, 2, 16'h0004, 1, 16'h0004);
    tbl[7]  = mk(1, 16'h0000, 0, 0, 1, 1, 2, 0, 0, 0);
    tbl[8]  = mk(1, 16'h0003, 16'h0002, 16'h0003, 1, 1, 2, 0, 0, 0);
    tbl[9]  = mk(1, 16'h0003, 16'h0002, 16'h0003, 1, 1, w1, N'(1) << w1, 1, N'(1) << w1);
    tbl[10] = mk(1, 16'h0001, 0, 16'h0001, 1, 1, w1, 0, 0, 0);
    tbl[11] = mk(1, 16'h0001, 0, 16'h0001, 1, 1, 0, 16'h0001, 1, 16'h0001);
    tbl[12] = mk(1, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rn, tbl[i].req, tbl[i].prio, tbl[i].last, tbl[i].rdy);
      if (tbl[i].chk_en) begin
        chk($sformatf("tbl%0d_sel", i),   32'(s_sel),   32'(tbl[i].sel));
        chk($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].grant));
        chk($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(tbl[i].busy));
        chk($sformatf("tbl%0d_pop", i),   32'(s_pop),   32'(tbl[i].pop));
      end
    end

    // Wrap: inputs 0 and 15 alternate with single-flit packets.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h8001, 0, 16'hFFFF, 1);
      if (s_busy === 1'b1) grants.push_back(int'(s_sel));
    end
    chk("wrap_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      chk($sformatf("wrap_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd0 : 32'd15);
    end

    // Backpressure then bubble on locked input 4 while everyone else requests.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0010, 0, 0, 1);
    cyc(1, 16'h0010, 0, 0, 1);
    chk("bp_first_pop", 32'(s_pop), 32'h0010);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cyc(1, 16'hFFFF, 0, 0, 0);
      else       cyc(1, 16'hFFEF, 0, 0, 1);
      chk($sformatf("bp%0d_pop", i),   32'(s_pop),   32'h0);
      chk($sformatf("bp%0d_sel", i),   32'(s_sel),   32'd4);
      chk($sformatf("bp%0d_grant", i), 32'(s_grant), 32'h0010);
      chk($sformatf("bp%0d_busy", i),  32'(s_busy),  32'd1);
    end
    cyc(1, 16'h0010, 0, 16'h0010, 1);
    chk("bp_last_pop", 32'(s_pop), 32'h0010);
    cyc(1, 16'h0000, 0, 0, 1);
    chk("bp_release", 32'(s_busy), 32'd0);

    // Reset mid-packet with the pointer at 5.
    cyc(1, 16'h0021, 0, 0, 1);
    cyc(1, 16'h0021, 0, 0, 1);
    chk("rst_pre_sel", 32'(s_sel), 32'd5);
    cyc(0, 16'h0021, 0, 0, 1);
    cyc(1, 16'h0021, 0, 0, 1);
    chk("rst_sel",   32'(s_sel),   32'd0);
    chk("rst_grant", 32'(s_grant), 32'h0);
    chk("rst_busy",  32'(s_busy),  32'd0);
    chk("rst_pop",   32'(s_pop),   32'h0);
    cyc(1, 16'h0021, 0, 0, 1);
    chk("rst_rearb_sel",   32'(s_sel),   32'd0);
    chk("rst_rearb_grant", 32'(s_grant), 32'h0001);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rq;
      rq = ($urandom_range(7) == 0) ? '0 : N'($urandom & $urandom);
      cyc(($urandom_range(99) != 0), rq, N'($urandom), N'($urandom & $urandom),
          ($urandom_range(3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/exa_crosb_out_arbiter.md
# exa_crosb_out_arbiter

Per-output arbiter of the crossbar: watches the head flits of all input ports competing for one output, picks a winner round-robin (high-priority class first), and drives the registered select into that output's crossbar mux. Holds the grant for a whole packet, up to and including the LAST flit. Generates per-input pop strobes toward the input buffers. One instance per crossbar output, directly upstream of the output's mux select.

## Interface
- input_num, 16, number of competing input ports (need not be a power of 2)
- sel_width, $clog2(input_num), width of the mux select
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- REQ_i  in  input_num  input i has a valid head flit for this output
- PRIO_i  in  input_num  head flit of input i is high-priority class
- LAST_i  in  input_num  head flit of input i is last of its packet
- READY_i  in  1  downstream accepts the muxed flit this cycle
- SEL_o  out  sel_width  registered select to crossbar mux
- GRANT_o  out  input_num  registered one-hot grant, zero when idle
- POP_o  out  input_num  combinational transfer strobe: GRANT_o & REQ_i & {READY_i}
- BUSY_o  out  1  registered, packet lock held; downstream qualifies mux VALID with it

## Operation
- States (arb_state_t): ARB_IDLE, ARB_LOCKED.
- ARB_IDLE, REQ_i == 0: stay, outputs unchanged (GRANT_o=0, BUSY_o=0).
- ARB_IDLE, REQ_i != 0: candidate set = REQ_i & PRIO_i if non-zero, else REQ_i. Winner = first set bit at or above that class's pointer, wrapping input_num-1 -> 0. Next edge: SEL_o=winner, GRANT_o=1<<winner, BUSY_o=1, class recorded, go ARB_LOCKED.
- ARB_LOCKED: transfer occurs when REQ_i[SEL_o] & READY_i (POP_o[SEL_o]=1). Transfer with LAST_i[SEL_o]=1: next edge go ARB_IDLE, GRANT_o=0, BUSY_o=0, recorded class pointer = (winner+1) mod input_num. SEL_o keeps last value.
- Locked input deasserting REQ mid-packet (bubble): lock held, no pop, no re-arbitration.
- READY_i=0: no pop, lock held, other requests ignored.
- Two pointers, rr_hi and rr_lo, each in 0..input_num-1; only the winning class's pointer advances. Pointer wrap: input_num-1 + 1 -> 0. SEL_o never >= input_num.
- Reset (any state, incl. mid-packet): next edge SEL_o=0, GRANT_o=0, BUSY_o=0, rr_hi=rr_lo=0, state ARB_IDLE; POP_o therefore 0. The lost partial packet is the input buffer's concern.

## Timing
- Grant latency: 1 cycle from REQ_i sampled in ARB_IDLE to GRANT_o/SEL_o valid.
- POP_o same-cycle combinational; no combinational path REQ_i -> SEL_o.
- Single-flit packet occupies 2 cycles (LOCKED with pop, then IDLE bubble); next grant earliest the edge after the IDLE cycle.
- N-flit packet, READY_i=1, no bubbles: BUSY_o high exactly N cycles.

## Configuration
- EXA_CROSB_ARB_PRIO_EN defined: two-class arbitration as above.
- Not defined: PRIO_i ignored, candidate set = REQ_i, only rr_lo exists/advances; rr_hi not instantiated.

## Structure
- Package exa_crosb_pkg: arb_state_t enum, shared input_num default constant.
- Sub-module exa_rr_pick: combinational round-robin picker (req vector, pointer -> found, index), instantiated once per class.

## Test plan
- Reset: resetn=0 for 2 cycles with REQ_i=0xFFFF -> SEL_o=0, GRANT_o=0, BUSY_o=0, POP_o=0.
- Single: REQ_i=0x0004, READY_i=1, 3-flit packet -> next cycle SEL_o=2, GRANT_o=0x0004; POP_o=0x0004 for 3 cycles; BUSY_o falls edge after third pop.
- Wrap: REQ_i=0x8001 held, single-flit packets -> grants 0,15,0,15; pointer wraps 15 -> 0.
- Priority (macro on): REQ_i=0x0003, PRIO_i=0x0002 -> input 1 first, then 0; macro off -> input 0 first.
- Backpressure/bubble: READY_i=0 4 cycles mid-packet, then REQ_i[SEL_o]=0 2 cycles, other REQ set -> POP_o=0, SEL_o/GRANT_o unchanged, BUSY_o=1 throughout.
- Reset mid-packet: resetn=0 while BUSY_o=1, pointer 5 -> next edge all outputs 0, next arbitration starts from pointer 0.
